reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; depth DEPTH = 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 wr_en  input  1  write request this cycle.
REQ-006 wr_addr  input  ADDR_W  default write target; also selects read port B.
REQ-007 dst_ovr  input  1  when high, the write goes to dst_addr instead of wr_addr.
REQ-008 dst_addr  input  ADDR_W  override write target.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 rd_addrA  input  ADDR_W  read port A address.
REQ-011 clr_req  input  1  pulse; starts a full-array clear sweep.
REQ-012 err_clr  input  1  clears the sticky wr_err flag.
REQ-013 datA_out  output  DATA_W  combinational read of rd_addrA.
REQ-014 datB_out  output  DATA_W  combinational read of wr_addr.
REQ-015 busy  output  1  high while the clear sweep runs.
REQ-016 wr_err  output  1  sticky; a write was dropped because busy was high.

Function
REQ-017 Effective write address SHALL be dst_addr when dst_ovr=1, else wr_addr.
REQ-018 Writes: when wr_en=1 and busy=0, mem[effective address] SHALL take wr_data at the rising edge; write latency is 1 cycle.
REQ-019 Reads SHALL be combinational, reflecting the stored value at that instant; both ports SHALL read the same address independently with no conflict.
REQ-020 FSM states: IDLE, CLEAR; pointer clr_ptr (ADDR_W bits).
REQ-021 IDLE with clr_req=1 -> CLEAR at the next edge, clr_ptr=0, busy=1 from that edge.
REQ-022 In CLEAR, each edge SHALL write 0 to mem[clr_ptr] and increment clr_ptr; at the edge that clears DEPTH-1, the FSM SHALL return to IDLE and drop busy; the sweep takes exactly DEPTH cycles.
REQ-023 clr_req while in CLEAR SHALL be ignored (no restart, no extension).
REQ-024 While busy=1, datA_out and datB_out SHALL read 0 regardless of array contents.
REQ-025 wr_en=1 while busy=1: the write SHALL be dropped and wr_err SHALL set at the same edge.
REQ-026 wr_err SHALL stay set until an edge with err_clr=1. If err_clr=1 and a dropped write coincide, set wins.
REQ-027 wr_en=1 and clr_req=1 in IDLE in the same cycle: the write SHALL complete, then the sweep SHALL start and overwrite it with 0.
REQ-028 clr_ptr SHALL wrap from DEPTH-1 to 0 without ever revisiting an entry within one sweep.

Reset
REQ-029 reset_n low SHALL immediately force: state CLEAR, clr_ptr=0, busy=1, wr_err=0, datA_out=datB_out=0.
REQ-030 The array SHALL NOT be asynchronously reset; after reset_n deasserts, the sweep SHALL zero all DEPTH entries, with busy falling DEPTH edges later.
REQ-031 Reset asserted mid-sweep or mid-write SHALL abort the operation and restart the sweep from entry 0 on deassertion.

Configuration
REQ-032 Macro REG_FILE_BYPASS_EN defined: when busy=0, wr_en=1 and a read address equals the effective write address, that read port SHALL output wr_data in the same cycle (write-to-read forwarding).
REQ-033 REG_FILE_BYPASS_EN undefined: the read port SHALL output the old stored value until the write edge; no forwarding logic SHALL be present.

Verification (DATA_W=8, ADDR_W=3)
REQ-034 Release reset, hold inputs idle -> busy=1 for 8 edges, then 0; all 8 entries read 0x00.
REQ-035 After the sweep, write 0xA5 to addr 3 with dst_ovr=0, then write 0x3C with wr_addr=3, dst_ovr=1, dst_addr=6 -> mem[3]=0xA5, mem[6]=0x3C, datB_out (wr_addr=3)=0xA5.
REQ-036 Pulse clr_req, assert wr_en (addr 2, 0x77) on sweep cycle 4 -> write dropped, wr_err=1 and held; mem[2]=0x00 after sweep; err_clr pulse -> wr_err=0.
REQ-037 In IDLE, wr_en to addr 5 with 0x11, rd_addrA=5 -> datA_out=0x11 in the same cycle with REG_FILE_BYPASS_EN, old value without; 0x11 after the edge in both builds.
REQ-038 Assert reset_n low at sweep cycle 5 after writing 0xFF to addr 7 -> outputs 0 immediately; after release, a full 8-cycle sweep runs and mem[7]=0x00.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write/override port, two read ports, clear sweep and error flag.
// The master side drives requests and the slave side (the register file) returns read data and status.
interface reg_file_mp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              dst_ovr;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addrA;
  logic              clr_req;
  logic              err_clr;
  logic [DATA_W-1:0] datA_out;
  logic [DATA_W-1:0] datB_out;
  logic              busy;
  logic              wr_err;

  modport master (
    output wr_en, wr_addr, dst_ovr, dst_addr, wr_data, rd_addrA, clr_req, err_clr,
    input  datA_out, datB_out, busy, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, dst_ovr, dst_addr, wr_data, rd_addrA, clr_req, err_clr,
    output datA_out, datB_out, busy, wr_err
  );
endinterface

// File: rtl/reg_file_mp.sv
// Two-read/one-write register file with a sequential clear sweep and a sticky dropped-write flag.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module reg_file_mp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic          clk,
  input logic          reset_n,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_next;
  logic              busy_int;
  logic              err_q;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;
  logic [DATA_W-1:0] mem [DEPTH];

  assign eff_addr = bus.dst_ovr ? bus.dst_addr : bus.wr_addr;

  // Reset lands in CLEAR so the array, which has no reset of its own, is swept after release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      CLEAR: begin
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == LAST_PTR) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  always_comb begin
    busy_int = (state == CLEAR);
  end

  // The sweep owns the write port while busy, so user writes are simply not performed
  always_ff @(posedge clk) begin
    if (busy_int) begin
      mem[clr_ptr] <= '0;
    end else if (bus.wr_en) begin
      mem[eff_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (bus.wr_en && busy_int) begin
      err_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_q <= 1'b0;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    read_a = mem[bus.rd_addrA];
    read_b = mem[bus.wr_addr];
    if (bus.wr_en && (bus.rd_addrA == eff_addr)) begin
      read_a = bus.wr_data;
    end
    if (bus.wr_en && (bus.wr_addr == eff_addr)) begin
      read_b = bus.wr_data;
    end
  end
`else
  always_comb begin
    read_a = mem[bus.rd_addrA];
    read_b = mem[bus.wr_addr];
  end
`endif

  assign bus.datA_out = busy_int ? '0 : read_a;
  assign bus.datB_out = busy_int ? '0 : read_b;
  assign bus.busy     = busy_int;
  assign bus.wr_err   = err_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed testbench for reg_file_mp: stimulus pushes expected outputs into a scoreboard queue,
// and a monitor pops and compares them on the falling edge. Honors REG_FILE_BYPASS_EN.
module tb_reg_file_mp;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int K_A    = 0;
  localparam int K_B    = 1;
  localparam int K_BUSY = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          kind;
    logic [7:0]  value;
    string       name;
  } exp_t;

  logic  clk;
  logic  reset_n;
  exp_t  sb[$];
  int    errors;
  int    checks;

  reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic ovr,
                               input logic [2:0] da, input logic [7:0] wd,
                               input logic [2:0] ra, input logic cr, input logic ec);
    @(posedge clk);
    #1;
    bus_if.wr_en    = we;
    bus_if.wr_addr  = wa;
    bus_if.dst_ovr  = ovr;
    bus_if.dst_addr = da;
    bus_if.wr_data  = wd;
    bus_if.rd_addrA = ra;
    bus_if.clr_req  = cr;
    bus_if.err_clr  = ec;
  endtask

  task automatic idleStep(input logic [2:0] ra);
    applyStimulus(1'b0, ra, 1'b0, 3'd0, 8'h00, ra, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input int kind, input logic [7:0] value, input string name);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    e.name  = name;
    sb.push_back(e);
  endtask

  // Monitor: everything queued during a cycle is compared against the settled outputs
  initial begin
    exp_t       e;
    logic [7:0] actual;
    errors = 0;
    checks = 0;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_A:     actual = bus_if.datA_out;
          K_B:     actual = bus_if.datB_out;
          K_BUSY:  actual = {7'd0, bus_if.busy};
          default: actual = {7'd0, bus_if.wr_err};
        endcase
        checks++;
        if (actual !== e.value) begin
          errors++;
          $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", e.name, actual, e.value);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n         = 1'b0;
    bus_if.wr_en    = 1'b0;
    bus_if.wr_addr  = '0;
    bus_if.dst_ovr  = 1'b0;
    bus_if.dst_addr = '0;
    bus_if.wr_data  = '0;
    bus_if.rd_addrA = '0;
    bus_if.clr_req  = 1'b0;
    bus_if.err_clr  = 1'b0;

    $display("[TB] reset state");
    checkOutput(K_BUSY, 8'd1, "reset_busy");
    checkOutput(K_ERR,  8'd0, "reset_err");
    checkOutput(K_A,    8'h00, "reset_datA");
    checkOutput(K_B,    8'h00, "reset_datB");
    idleStep(3'd0);
    checkOutput(K_BUSY, 8'd1, "reset_hold_busy");

    $display("[TB] initial sweep after release");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput(K_BUSY, 8'd1, "release_busy");
    for (int k = 1; k <= 8; k++) begin
      idleStep(3'd0);
      checkOutput(K_BUSY, (k < 8) ? 8'd1 : 8'd0, $sformatf("sweep0_busy_edge%0d", k));
    end
    for (int a = 0; a < 8; a++) begin
      idleStep(3'(a));
      checkOutput(K_A, 8'h00, $sformatf("sweep0_entry%0d", a));
    end

    $display("[TB] default and override write targets");
    applyStimulus(1'b1, 3'd3, 1'b0, 3'd0, 8'hA5, 3'd3, 1'b0, 1'b0);
    checkOutput(K_B, BYPASS ? 8'hA5 : 8'h00, "wr3_datB_same_cycle");
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd6, 8'h3C, 3'd3, 1'b0, 1'b0);
    checkOutput(K_A, 8'hA5, "ovr_datA_mem3");
    checkOutput(K_B, 8'hA5, "ovr_datB_mem3");
    applyStimulus(1'b0, 3'd3, 1'b0, 3'd0, 8'h00, 3'd6, 1'b0, 1'b0);
    checkOutput(K_A, 8'h3C, "ovr_mem6");
    checkOutput(K_B, 8'hA5, "ovr_datB_wraddr3");

    $display("[TB] dropped write during sweep");
    applyStimulus(1'b0, 3'd2, 1'b0, 3'd0, 8'h00, 3'd2, 1'b1, 1'b0);
    checkOutput(K_BUSY, 8'd0, "clr1_busy_before_edge");
    for (int j = 1; j <= 9; j++) begin
      if (j == 4) begin
        applyStimulus(1'b1, 3'd2, 1'b0, 3'd0, 8'h77, 3'd2, 1'b0, 1'b0);
      end else begin
        idleStep(3'd2);
      end
      checkOutput(K_BUSY, (j <= 8) ? 8'd1 : 8'd0, $sformatf("clr1_busy_cycle%0d", j));
      checkOutput(K_ERR, (j >= 5) ? 8'd1 : 8'd0, $sformatf("clr1_err_cycle%0d", j));
      if (j <= 8) checkOutput(K_A, 8'h00, $sformatf("clr1_datA_masked%0d", j));
    end
    idleStep(3'd2);
    checkOutput(K_A, 8'h00, "clr1_mem2_dropped");
    checkOutput(K_ERR, 8'd1, "clr1_err_held");
    applyStimulus(1'b0, 3'd2, 1'b0, 3'd0, 8'h00, 3'd2, 1'b0, 1'b1);
    checkOutput(K_ERR, 8'd1, "err_clr_before_edge");
    idleStep(3'd2);
    checkOutput(K_ERR, 8'd0, "err_clr_after_edge");

    $display("[TB] same-cycle read of write target");
    applyStimulus(1'b1, 3'd5, 1'b0, 3'd0, 8'h11, 3'd5, 1'b0, 1'b0);
    checkOutput(K_A, BYPASS ? 8'h11 : 8'h00, "fwd_datA_same_cycle");
    checkOutput(K_B, BYPASS ? 8'h11 : 8'h00, "fwd_datB_same_cycle");
    idleStep(3'd5);
    checkOutput(K_A, 8'h11, "fwd_datA_after_edge");

    $display("[TB] write with clear request, error set wins over clear");
    applyStimulus(1'b1, 3'd4, 1'b0, 3'd0, 8'h5A, 3'd4, 1'b1, 1'b0);
    checkOutput(K_BUSY, 8'd0, "wrclr_busy_before_edge");
    checkOutput(K_A, BYPASS ? 8'h5A : 8'h00, "wrclr_datA_same_cycle");
    for (int j = 1; j <= 9; j++) begin
      if (j == 2) begin
        applyStimulus(1'b1, 3'd1, 1'b0, 3'd0, 8'h99, 3'd4, 1'b0, 1'b1);
      end else begin
        idleStep(3'd4);
      end
      if (j == 1) checkOutput(K_A, 8'h00, "wrclr_datA_masked");
      if (j == 2) checkOutput(K_ERR, 8'd0, "setwins_err_before_edge");
      if (j == 3) checkOutput(K_ERR, 8'd1, "setwins_err_after_edge");
      if (j == 8) checkOutput(K_BUSY, 8'd1, "wrclr_busy_last_cycle");
      if (j == 9) checkOutput(K_BUSY, 8'd0, "wrclr_busy_done");
      if (j == 9) checkOutput(K_A, 8'h00, "wrclr_mem4_overwritten");
    end
    idleStep(3'd1);
    checkOutput(K_A, 8'h00, "wrclr_mem1_dropped");
    applyStimulus(1'b0, 3'd1, 1'b0, 3'd0, 8'h00, 3'd1, 1'b0, 1'b1);
    idleStep(3'd1);
    checkOutput(K_ERR, 8'd0, "wrclr_err_cleared");

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(1'b1, 3'd7, 1'b0, 3'd0, 8'hFF, 3'd7, 1'b0, 1'b0);
    idleStep(3'd7);
    checkOutput(K_A, 8'hFF, "rst_mem7_written");
    applyStimulus(1'b0, 3'd7, 1'b0, 3'd0, 8'h00, 3'd7, 1'b1, 1'b0);
    for (int j = 1; j <= 5; j++) begin
      if (j == 2) begin
        applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 8'h42, 3'd7, 1'b0, 1'b0);
      end else begin
        idleStep(3'd7);
      end
      if (j == 4) checkOutput(K_ERR, 8'd1, "rst_err_set_before_reset");
    end
    #2;
    reset_n = 1'b0;
    checkOutput(K_BUSY, 8'd1, "rst_mid_busy");
    checkOutput(K_ERR,  8'd0, "rst_mid_err");
    checkOutput(K_A,    8'h00, "rst_mid_datA");
    checkOutput(K_B,    8'h00, "rst_mid_datB");
    idleStep(3'd7);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput(K_BUSY, 8'd1, "rst_release_busy");
    for (int k = 1; k <= 8; k++) begin
      idleStep(3'd7);
      checkOutput(K_BUSY, (k < 8) ? 8'd1 : 8'd0, $sformatf("sweep2_busy_edge%0d", k));
    end
    checkOutput(K_A, 8'h00, "rst_mem7_cleared_A");
    checkOutput(K_B, 8'h00, "rst_mem7_cleared_B");

    idleStep(3'd0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
